// File: rtl/matrix_stream_receiver.sv
// -----------------------------------------------------------------------------
// matrix_stream_receiver
//
// Receiving end of the bicolor 8x8 LED-matrix serial link. Rebuilds the
// 2-colour x 8-row x 8-bit frame from the shift-clock / serial-data / latch /
// column-strobe stream the matrix driver sends to its shift registers. Each
// committed row is reported as a one-cycle write event and stored in an
// internal frame buffer that the host reads through a registered port.
//
// Parameters
//   SYNC_STAGES     synchronizer depth for every link input (2..4)
//   TIMEOUT_CYCLES  clk cycles without a shift edge before link_active drops
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   ser_clk      link shift clock (async); data taken on its rising edge
//   ser_data     link serial data, first bit received lands in bit 0
//   ser_latch    link storage clock; rising edge commits the shifted byte
//   col_red_n    active-low red column strobe, sampled with each shift
//   col_green_n  active-low green column strobe, sampled with each shift
//   rd_color     read colour select (0 = red, 1 = green)
//   rd_row       read row select
//   rd_data      registered frame-buffer byte, 1-cycle latency, write-first
//   wr_valid     one-cycle pulse when a row is committed
//   wr_color     colour of the committed row (valid with wr_valid)
//   wr_row       row index of the committed row (valid with wr_valid)
//   wr_data      committed byte (valid with wr_valid)
//   frame_done   one-cycle pulse together with the green row 7 write
//   err          one-cycle pulse on a rejected latch
//   err_count    saturating count of rejected latches
//   link_active  high while shift edges arrive within TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module matrix_stream_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_clk,
    input  logic       ser_data,
    input  logic       ser_latch,
    input  logic       col_red_n,
    input  logic       col_green_n,
    input  logic       rd_color,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_data,
    output logic       wr_valid,
    output logic       wr_color,
    output logic [2:0] wr_row,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       err,
    output logic [7:0] err_count,
    output logic       link_active
);

    localparam int                IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    // All link inputs travel through the synchronizer together as one word.
    typedef struct packed {
        logic clk;
        logic data;
        logic latch;
        logic red_n;
        logic green_n;
    } link_t;

    // ------------------------------------------------------------------------
    // Input conditioning and edge detection
    // ------------------------------------------------------------------------
    link_t [SYNC_STAGES-1:0] sync_q;
    link_t                   raw_in;
    link_t                   link;

    logic clk_prev;
    logic latch_prev;
    logic shift_evt;
    logic latch_evt;

    assign raw_in = '{clk: ser_clk, data: ser_data, latch: ser_latch,
                      red_n: col_red_n, green_n: col_green_n};
    assign link   = sync_q[SYNC_STAGES-1];

    // Edge pulses are registered so that a shift and a latch seen together
    // reach the datapath in the same cycle and are resolved in one place.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            clk_prev   <= 1'b0;
            latch_prev <= 1'b0;
            shift_evt  <= 1'b0;
            latch_evt  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], raw_in};
            clk_prev   <= link.clk;
            latch_prev <= link.latch;
            shift_evt  <= link.clk & ~clk_prev;
            latch_evt  <= link.latch & ~latch_prev;
        end
    end

    // ------------------------------------------------------------------------
    // Shift / strobe bookkeeping
    // ------------------------------------------------------------------------
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
    logic [3:0] bit_cnt;
    logic [1:0] strobe_cnt;
    logic [2:0] row_cap;
    logic       color_cap;

    logic [7:0] nxt_shift_reg;
    logic [2:0] nxt_bit_idx;
    logic [3:0] nxt_bit_cnt;
    logic [1:0] nxt_strobe_cnt;
    logic [2:0] nxt_row_cap;
    logic       nxt_color_cap;
    logic       accept;
    logic       reject;

    // The shift is applied first; the latch decision looks at the post-shift
    // values so a coincident shift+latch behaves like shift-then-latch.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        nxt_shift_reg  = shift_reg;
        nxt_bit_idx    = bit_idx;
        nxt_bit_cnt    = bit_cnt;
        nxt_strobe_cnt = strobe_cnt;
        nxt_row_cap    = row_cap;
        nxt_color_cap  = color_cap;

        if (shift_evt) begin
            nxt_shift_reg[bit_idx] = link.data;
            nxt_bit_idx            = bit_idx + 3'd1;
            if (bit_cnt != 4'd15) begin
                nxt_bit_cnt = bit_cnt + 4'd1;
            end
            if (!link.red_n && !link.green_n) begin
                // Both colours driven at once is never legal: poison the row.
                nxt_strobe_cnt = 2'd3;
            end else if (link.red_n != link.green_n) begin
                if (strobe_cnt != 2'd3) begin
                    nxt_strobe_cnt = strobe_cnt + 2'd1;
                end
                nxt_row_cap   = bit_idx;
                nxt_color_cap = ~link.green_n;
            end
        end

        accept = latch_evt && (nxt_bit_cnt == 4'd8) && (nxt_strobe_cnt == 2'd1);
        reject = latch_evt && !accept;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_idx    <= '0;
            bit_cnt    <= '0;
            strobe_cnt <= '0;
            row_cap    <= '0;
            color_cap  <= 1'b0;
        end else begin
            shift_reg <= nxt_shift_reg;
            row_cap   <= nxt_row_cap;
            color_cap <= nxt_color_cap;
            if (latch_evt) begin
                // Accepted or not, a latch always starts a fresh row.
                bit_idx    <= '0;
                bit_cnt    <= '0;
                strobe_cnt <= '0;
            end else begin
                bit_idx    <= nxt_bit_idx;
                bit_cnt    <= nxt_bit_cnt;
                strobe_cnt <= nxt_strobe_cnt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame buffer and read port
    // ------------------------------------------------------------------------
    logic [7:0] frame_buf [16];
    logic [3:0] wr_addr;
    logic [3:0] rd_addr;

    assign wr_addr = {nxt_color_cap, nxt_row_cap};
    assign rd_addr = {rd_color, rd_row};

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the buffer is only 16 bytes of flops and must read back as
            // zero after reset, so it is cleared rather than left as RAM.
            for (int i = 0; i < 16; i++) begin
                frame_buf[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (accept) begin
                frame_buf[wr_addr] <= nxt_shift_reg;
            end
            // Bypass gives write-first behaviour for a same-cycle read.
            if (accept && (wr_addr == rd_addr)) begin
                rd_data <= nxt_shift_reg;
            end else begin
                rd_data <= frame_buf[rd_addr];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write events, errors and link monitor
    // ------------------------------------------------------------------------
    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid   <= 1'b0;
            wr_color   <= 1'b0;
            wr_row     <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
        end else begin
            wr_valid   <= accept;
            frame_done <= accept && nxt_color_cap && (nxt_row_cap == 3'd7);
            err        <= reject;
            if (accept) begin
                wr_color <= nxt_color_cap;
                wr_row   <= nxt_row_cap;
                wr_data  <= nxt_shift_reg;
            end
            if (reject && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // The idle counter comes out of reset already saturated, so the link
    // reads inactive until the first shift edge is actually seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= IDLE_MAX;
        end else if (shift_evt) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign link_active = (idle_cnt < IDLE_MAX);

endmodule

// File: tb/tb_matrix_stream_receiver.sv
// -----------------------------------------------------------------------------
// tb_matrix_stream_receiver
//
// Directed bench for matrix_stream_receiver with SYNC_STAGES=2 and
// TIMEOUT_CYCLES=16. Every link phase is held 4 clk cycles, which exceeds the
// SYNC_STAGES+1 minimum. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_matrix_stream_receiver;

    localparam int SYNC = 2;
    localparam int TO   = 16;

    logic       clk;
    logic       rst;
    logic       ser_clk;
    logic       ser_data;
    logic       ser_latch;
    logic       col_red_n;
    logic       col_green_n;
    logic       rd_color;
    logic [2:0] rd_row;
    logic [7:0] rd_data;
    logic       wr_valid;
    logic       wr_color;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       err;
    logic [7:0] err_count;
    logic       link_active;

    matrix_stream_receiver #(
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_clk    (ser_clk),
        .ser_data   (ser_data),
        .ser_latch  (ser_latch),
        .col_red_n  (col_red_n),
        .col_green_n(col_green_n),
        .rd_color   (rd_color),
        .rd_row     (rd_row),
        .rd_data    (rd_data),
        .wr_valid   (wr_valid),
        .wr_color   (wr_color),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .err        (err),
        .err_count  (err_count),
        .link_active(link_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Event tallies collected on the falling edge, away from the active edge.
    int         wr_seen  = 0;
    int         err_seen = 0;
    int         fd_seen  = 0;
    int         fd_bad   = 0;
    logic       last_color;
    logic [2:0] last_row;
    logic [7:0] last_data;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid) begin
                wr_seen++;
                last_color = wr_color;
                last_row   = wr_row;
                last_data  = wr_data;
            end
            if (err) err_seen++;
            if (frame_done) begin
                fd_seen++;
                if (!(wr_valid && wr_color && (wr_row == 3'd7))) fd_bad++;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 1ms", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string name, input logic c, input logic [2:0] r,
                              input logic [7:0] exp);
        rd_color = c;
        rd_row   = r;
        tick(1);
        check(name, rd_data, exp);
    endtask

    // Shift nbits of b (bit 0 first). The strobe of colour c is driven low on
    // shift strobe_idx; with both set, both strobes are driven low there.
    task automatic send_shifts(input logic [7:0] b, input int nbits, input logic c,
                               input int strobe_idx, input logic both);
        for (int i = 0; i < nbits; i++) begin
            ser_data    = b[i[2:0]];
            col_red_n   = !((i == strobe_idx) && (!c || both));
            col_green_n = !((i == strobe_idx) && (c || both));
            tick(4);
            ser_clk = 1'b1;
            tick(4);
            ser_clk     = 1'b0;
            col_red_n   = 1'b1;
            col_green_n = 1'b1;
        end
    endtask

    task automatic pulse_latch();
        ser_latch = 1'b1;
        tick(4);
        ser_latch = 1'b0;
        tick(4);
    endtask

    // Latch and measure how many edges after the sampling edge the event
    // appears; rd_at captures rd_data in that same sample.
    task automatic latch_wait(output int lat, output logic [7:0] rd_at);
        lat       = -1;
        rd_at     = 8'h00;
        ser_latch = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (lat < 0 && (wr_valid || err)) begin
                lat   = i;
                rd_at = rd_data;
            end
        end
        ser_latch = 1'b0;
        tick(4);
    endtask

    int         lat;
    logic [7:0] rd_at;
    int         rise;
    int         high_cnt;

    initial begin
        rst         = 1'b1;
        ser_clk     = 1'b0;
        ser_data    = 1'b0;
        ser_latch   = 1'b0;
        col_red_n   = 1'b1;
        col_green_n = 1'b1;
        rd_color    = 1'b0;
        rd_row      = 3'd0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // ---- reset state ----
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_err_count", err_count, 8'd0);
        check("rst_link_active", link_active, 1'b0);
        for (int a = 0; a < 16; a++) begin
            read_check("rst_rd_data", a[3], a[2:0], 8'h00);
        end

        // ---- single row: bits 1,1,0,1,0,0,0,0, red strobe on shift 3 ----
        rd_color = 1'b1;
        rd_row   = 3'd7;
        send_shifts(8'h0B, 8, 1'b0, 3, 1'b0);
        latch_wait(lat, rd_at);
        check("row_latency", lat, SYNC + 1);
        check("row_wr_count", wr_seen, 1);
        check("row_wr_color", last_color, 1'b0);
        check("row_wr_row", last_row, 3'd3);
        check("row_wr_data", last_data, 8'h0B);
        check("row_err_count", err_seen, 0);
        read_check("row_readback", 1'b0, 3'd3, 8'h0B);

        // ---- full frame: red 0..7 then green 0..7, byte = row*17 ----
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 8; r++) begin
                send_shifts(8'(r * 17), 8, c[0], r, 1'b0);
                pulse_latch();
            end
        end
        check("frame_wr_count", wr_seen, 17);
        check("frame_done_count", fd_seen, 1);
        check("frame_done_placement", fd_bad, 0);
        check("frame_last_color", last_color, 1'b1);
        check("frame_last_row", last_row, 3'd7);
        check("frame_last_data", last_data, 8'h77);
        for (int a = 0; a < 16; a++) begin
            read_check("frame_readback", a[3], a[2:0], 8'((a % 8) * 17));
        end

        // ---- malformed rows: 7 shifts, no strobe, both strobes ----
        send_shifts(8'hFF, 7, 1'b0, 2, 1'b0);
        pulse_latch();
        send_shifts(8'hFF, 8, 1'b0, -1, 1'b0);
        pulse_latch();
        send_shifts(8'hFF, 8, 1'b0, 4, 1'b1);
        pulse_latch();
        check("bad_err_pulses", err_seen, 3);
        check("bad_err_count", err_count, 8'd3);
        check("bad_wr_count", wr_seen, 17);
        for (int a = 0; a < 16; a++) begin
            read_check("bad_readback", a[3], a[2:0], 8'((a % 8) * 17));
        end

        // ---- 260 empty latches saturate err_count ----
        repeat (260) pulse_latch();
        check("sat_err_pulses", err_seen, 263);
        check("sat_err_count", err_count, 8'd255);

        // Valid row afterwards, reading the same entry as it is written.
        rd_color = 1'b0;
        rd_row   = 3'd5;
        tick(1);
        check("bypass_old", rd_data, 8'h55);
        send_shifts(8'hA5, 8, 1'b0, 5, 1'b0);
        latch_wait(lat, rd_at);
        check("sat_row_latency", lat, SYNC + 1);
        check("bypass_write_first", rd_at, 8'hA5);
        check("sat_wr_count", wr_seen, 18);
        check("sat_wr_data", last_data, 8'hA5);
        check("sat_err_hold", err_count, 8'd255);
        read_check("sat_readback", 1'b0, 3'd5, 8'hA5);

        // ---- reset coinciding with a latch event discards the row ----
        send_shifts(8'h3C, 8, 1'b1, 2, 1'b0);
        ser_latch = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(4);
        ser_latch = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(8);
        check("rstmid_wr_count", wr_seen, 18);
        check("rstmid_err_pulses", err_seen, 263);
        check("rstmid_err_count", err_count, 8'd0);
        read_check("rstmid_green2", 1'b1, 3'd2, 8'h00);
        read_check("rstmid_red5", 1'b0, 3'd5, 8'h00);

        // ---- link_active timeout ----
        check("link_idle", link_active, 1'b0);
        for (int p = 0; p < 2; p++) begin
            rise     = -1;
            ser_clk  = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (rise < 0 && link_active) rise = i;
            end
            ser_clk = 1'b0;
            check("link_rise", rise, SYNC + 1);
            // 8 edges already passed after the sampling edge; rise came at
            // edge 3, so 5 high samples (edges 3..7) are already in.
            high_cnt = (rise >= 0) ? 8 - rise : 0;
            for (int i = 0; i < 40; i++) begin
                tick(1);
                if (link_active) high_cnt++;
                else break;
            end
            check("link_high_cycles", high_cnt, TO);
            check("link_fallen", link_active, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_stream_receiver.md
# matrix_stream_receiver

Receiving end of the bicolor 8x8 LED-matrix serial link. It reconstructs the 2-colour × 8-row × 8-bit frame from the shift-clock / serial-data / latch / column-strobe stream that the matrix driver emits toward its shift registers. It sits on the board as a loopback checker or secondary-panel decoder. It exposes each decoded row as a one-cycle write event and holds the complete frame in an internal buffer readable by the host logic.

## Interface
- SYNC_STAGES, 2, synchronizer depth for every serial-link input (legal 2..4)
- TIMEOUT_CYCLES, 16384, clk cycles without a shift edge before link_active drops (legal ≥ 2)
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- ser_clk  input  1  link shift clock, asynchronous to clk; data sampled on its rising edge
- ser_data  input  1  link serial data
- ser_latch  input  1  link storage-register clock; rising edge commits the shifted byte
- col_red_n  input  1  active-low red column strobe, sampled with each shift edge
- col_green_n  input  1  active-low green column strobe, sampled with each shift edge
- rd_color  input  1  read port colour select (0 = red, 1 = green)
- rd_row  input  3  read port row select
- rd_data  output  8  registered frame-buffer byte
- wr_valid  output  1  one-cycle pulse when a row is committed
- wr_color  output  1  colour of the committed row (valid with wr_valid)
- wr_row  output  3  row index of the committed row (valid with wr_valid)
- wr_data  output  8  committed byte (valid with wr_valid)
- frame_done  output  1  one-cycle pulse, coincident with wr_valid for green row 7
- err  output  1  one-cycle pulse on a rejected latch
- err_count  output  8  saturating count of rejected latches
- link_active  output  1  high while shift edges arrive within TIMEOUT_CYCLES

## Operation
- Input conditioning: ser_clk, ser_data, ser_latch, col_red_n and col_green_n each pass through a SYNC_STAGES flop chain. A registered previous value of the synced ser_clk and ser_latch gives rise-edge pulses.
- Shift event (synced ser_clk rise):
  - shift_reg[bit_idx] <= ser_data, so the first bit received lands in bit 0.
  - bit_idx increments, wrapping 7→0.
  - bit_cnt increments, saturating at 15.
  - If exactly one strobe is low: strobe_cnt increments (saturates at 3), row_cap <= bit_idx, color_cap <= (col_green_n == 0).
  - If both strobes are low: strobe_cnt <= 3, which forces an error.
- Latch event (synced ser_latch rise):
  - Accepted if bit_cnt == 8 and strobe_cnt == 1. On accept: buffer[color_cap][row_cap] <= shift_reg, and pulse wr_valid with wr_color/wr_row/wr_data.
  - Otherwise rejected: pulse err, increment err_count (stays at 255 once reached). The buffer is unchanged.
  - Either outcome clears bit_cnt, bit_idx and strobe_cnt.
- A shift event and a latch event detected in the same cycle: the shift is applied first, and the latch evaluates the updated counters and shift_reg.
- frame_done: pulses with an accepted write where color == 1 and row == 7.
- link_active:
  - An idle counter resets to 0 on each shift event and otherwise increments, saturating at TIMEOUT_CYCLES.
  - link_active = (counter < TIMEOUT_CYCLES).

## Timing
- Reset values:
  - All outputs 0, including rd_data, err_count and link_active.
  - Frame buffer all 0.
  - Synchronizers, edge registers, counters and shift_reg all 0.
- Event latency: wr_valid / err asserts SYNC_STAGES+1 clk cycles after the first clk edge at which ser_latch is sampled high, provided ser_latch is stable for ≥ 2 clk cycles.
- Link period: ser_clk and ser_latch high and low phases must each be ≥ SYNC_STAGES+1 clk cycles. Narrower pulses may be lost; this is unspecified but must not corrupt counters outside their ranges.
- Read port: rd_data registered, 1-cycle latency from rd_color/rd_row. A read of the entry written in the same cycle returns the new data one cycle later (write-first).
- Reset mid-operation: a rst asserted in the same cycle as a latch event takes priority. No write and no err occur, and the partial row is discarded.

## Test plan
- Reset → all outputs 0, link_active 0, rd_data 0 for all 16 addresses.
- Stream data bits 1,1,0,1,0,0,0,0 (bit 0 first) with col_red_n low only on shift 3, then latch → one wr_valid with wr_color=0, wr_row=3, wr_data=0x0B. Reading (0,3) returns 0x0B one cycle later.
- Full frame of 16 valid rows (red 0..7, then green 0..7), each byte = row×17 → 16 wr_valid pulses. frame_done fires with the green row 7 write only. Readback of all entries matches.
- Latch after 7 shifts; latch after 8 shifts with no strobe; latch after 8 shifts with both strobes low → 3 err pulses, err_count=3, buffer unchanged.
- 260 malformed latches → err_count saturates at 255. A subsequent valid row still writes.
- Stop ser_clk with TIMEOUT_CYCLES=16 → link_active falls exactly 16 cycles after the last detected shift event, and rises the cycle after the next shift event.
